ram4: RTL and testbench

- Four-word register bank, one write port and one read port, on the same select path.
- Write `load` fans out to four word registers through a 1-to-4 demultiplex on `address`: word k loads only when `address == k` and `load` is 1.
- Read output is a 4-to-1 multiplex of the registered words, also on `address`.
- Building block for the larger RAM8/RAM64 hierarchy in the memory path; sits directly downstream of the 4-way load demultiplexer.

---
 rtl/ram4_pkg.sv | 20 ++
 rtl/ram4_word_reg.sv | 34 +++
 rtl/ram4.sv | 58 +++++
 tb/tb_ram4.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ram4_pkg.sv
// ram4_pkg: constants shared by the ram4 bank and the RAM8/RAM64 levels
// built on top of it.
//   DATA_W  default word width
//   ADDR_W  word-select width of one four-word bank
//   DEPTH   words per bank
//   decode  one-hot decode of a bank word select
package ram4_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 2;
   localparam int DEPTH  = 4;

   function automatic logic [DEPTH-1:0] decode(input logic [ADDR_W-1:0] a);
      logic [DEPTH-1:0] v;
      v    = '0;
      v[a] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/ram4_word_reg.sv
// word_reg: one WIDTH-bit storage word with synchronous active-high reset
// and load enable.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous reset, loads RESET_VALUE
//   load   capture in on the next rising edge
//   in     write data
//   out    stored word
module word_reg
   import ram4_pkg::*;
#(
   parameter int               WIDTH       = DATA_W,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] r_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_word <= RESET_VALUE;
      end else if (load) begin
         r_word <= in;
      end
   end

   assign out = r_word;

endmodule

// File: rtl/ram4.sv
// ram4: four-word register bank with a single shared address for the
// write and read ports.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous active-high reset (overrides load)
//   in       write data
//   load     write enable for the addressed word
//   address  word select for both write and read
//   out      combinational read of the addressed word
//   written  sticky per-word flags, set on load, cleared only by reset
module ram4
   import ram4_pkg::*;
#(
   parameter int               WIDTH       = DATA_W,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WIDTH-1:0]  in,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   output logic [WIDTH-1:0]  out,
   output logic [DEPTH-1:0]  written
);

   logic [DEPTH-1:0] w_load;
   logic [WIDTH-1:0] w_words [DEPTH];
   logic [DEPTH-1:0] r_written;

   assign w_load = load ? decode(address) : '0;

   for (genvar k = 0; k < DEPTH; k++) begin : g_word
      word_reg #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_word (
         .clk   (clk),
         .reset (reset),
         .load  (w_load[k]),
         .in    (in),
         .out   (w_words[k])
      );
   end

   // Flags only ever set here; reset is the sole way to clear them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_written <= '0;
      end else begin
         r_written <= r_written | w_load;
      end
   end

   // Read straight from the stored words; no forwarding of in.
   assign out     = w_words[address];
   assign written = r_written;

endmodule

// File: tb/tb_ram4.sv
module tb_ram4;

   logic        clk;
   logic        reset;
   logic [15:0] in;
   logic        load;
   logic [1:0]  address;
   logic [15:0] out;
   logic [3:0]  written;

   int n_cmp;
   int n_err;

   logic [15:0] vals [4];

   ram4 #(.WIDTH(16), .RESET_VALUE(16'h0000)) dut (
      .clk     (clk),
      .reset   (reset),
      .in      (in),
      .load    (load),
      .address (address),
      .out     (out),
      .written (written)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("tag %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic rd(input string tag, input logic [1:0] a, input logic [15:0] exp);
      address = a;
      #1;
      chk(tag, out, exp);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      vals[0] = 16'h1111;
      vals[1] = 16'h2222;
      vals[2] = 16'h3333;
      vals[3] = 16'h4444;

      // reset wins over a simultaneous load
      reset   = 1'b1;
      load    = 1'b1;
      in      = 16'hFFFF;
      address = 2'b10;
      tick();
      reset = 1'b0;
      load  = 1'b0;
      rd("rst_a0", 2'd0, 16'h0000);
      rd("rst_a1", 2'd1, 16'h0000);
      rd("rst_a2", 2'd2, 16'h0000);
      rd("rst_a3", 2'd3, 16'h0000);
      chk("rst_written", {12'h0, written}, 16'h0000);

      // write all four words on consecutive edges
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         in      = vals[a];
         load    = 1'b1;
         tick();
      end
      load = 1'b0;
      rd("wr_a0", 2'd0, 16'h1111);
      rd("wr_a1", 2'd1, 16'h2222);
      rd("wr_a2", 2'd2, 16'h3333);
      rd("wr_a3", 2'd3, 16'h4444);
      chk("wr_written", {12'h0, written}, 16'h000F);

      // write-to-read latency of one cycle
      address = 2'd1;
      in      = 16'hBEEF;
      load    = 1'b1;
      #1;
      chk("lat_before", out, 16'h2222);
      tick();
      chk("lat_after", out, 16'hBEEF);
      load = 1'b0;
      rd("lat_a0", 2'd0, 16'h1111);
      rd("lat_a2", 2'd2, 16'h3333);
      rd("lat_a3", 2'd3, 16'h4444);
      chk("lat_written", {12'h0, written}, 16'h000F);

      // load low: nothing changes
      in   = 16'hDEAD;
      load = 1'b0;
      for (int a = 0; a < 4; a++) begin
         address = 2'(a);
         tick();
      end
      rd("ll_a0", 2'd0, 16'h1111);
      rd("ll_a1", 2'd1, 16'hBEEF);
      rd("ll_a2", 2'd2, 16'h3333);
      rd("ll_a3", 2'd3, 16'h4444);
      chk("ll_written", {12'h0, written}, 16'h000F);

      // mid-burst reset
      address = 2'd0;
      in      = 16'hAAAA;
      load    = 1'b1;
      tick();
      chk("mb_a0_aaaa", out, 16'hAAAA);
      reset   = 1'b1;
      address = 2'd3;
      in      = 16'h5555;
      load    = 1'b1;
      tick();
      reset = 1'b0;
      load  = 1'b0;
      rd("mb_a0", 2'd0, 16'h0000);
      rd("mb_a1", 2'd1, 16'h0000);
      rd("mb_a2", 2'd2, 16'h0000);
      rd("mb_a3", 2'd3, 16'h0000);
      chk("mb_written", {12'h0, written}, 16'h0000);

      address = 2'd3;
      in      = 16'h7777;
      load    = 1'b1;
      tick();
      load = 1'b0;
      in   = 16'h0123;
      rd("rs_a3", 2'd3, 16'h7777);
      chk("rs_written", {12'h0, written}, 16'h0008);
      rd("rs_a0", 2'd0, 16'h0000);

      // rewrite keeps sticky flag, other address unaffected
      address = 2'd3;
      in      = 16'h8888;
      load    = 1'b1;
      tick();
      load = 1'b0;
      rd("rw_a3", 2'd3, 16'h8888);
      chk("rw_written", {12'h0, written}, 16'h0008);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
